// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: bit-serial double-dabble binary-to-BCD converter with valid/ready handshakes.
// Define BIN2BCD_SIGNED_EN to treat binary as two's complement and report the sign.
module bin2bcd_seq #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      binary,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  ovf,
   output logic                  sign
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t              state_q, state_d;
   logic [WIDTH-1:0]    bin_q, bin_d, mag;
   logic [4*DIGITS-1:0] bcd_q, bcd_d, adj;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                ovf_q, ovf_d, sign_q, sign_d, out_valid_q, out_valid_d, neg;
`ifdef BIN2BCD_SIGNED_EN
   assign neg = binary[WIDTH-1];
   assign mag = neg ? -binary : binary;
`else
   assign neg = 1'b0;
   assign mag = binary;
`endif
   assign in_ready  = (state_q == IDLE) & ~rst;
   assign out_valid = out_valid_q;
   assign bcd       = bcd_q;
   assign ovf       = ovf_q;
   assign sign      = sign_q;
   always_comb begin
      adj = bcd_q;
      for (int k = 0; k < DIGITS; k++)
         adj[4*k+:4] = (bcd_q[4*k+:4] >= 4'd5) ? bcd_q[4*k+:4] + 4'd3 : bcd_q[4*k+:4];
      state_d     = state_q;
      bin_d       = bin_q;
      bcd_d       = bcd_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      sign_d      = sign_q;
      out_valid_d = out_valid_q;
      case (state_q)
         IDLE: if (in_valid) begin
            bin_d   = mag;
            bcd_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            sign_d  = neg;
            state_d = SHIFT;
         end
         SHIFT: begin
            // a set top bit after adjust is a carry past the last digit, i.e. a lost 10^DIGITS
            ovf_d          = ovf_q | adj[4*DIGITS-1];
            {bcd_d, bin_d} = {adj[4*DIGITS-2:0], bin_q, 1'b0};
            cnt_d          = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
            end
         end
         DONE: if (out_ready) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         bin_q       <= '0;
         bcd_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         sign_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bin_q       <= bin_d;
         bcd_q       <= bcd_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         sign_q      <= sign_d;
         out_valid_q <= out_valid_d;
      end
   end
endmodule
